// File: rtl/intr_sched_pkg.sv
// Shared definitions for the interrupt scheduler: FSM/grant encodings,
// dispatch priority and default parameters.
package intr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_NXM  = 2'd1,
    GNT_PI   = 2'd2,
    GNT_TIM  = 2'd3
  } grant_e;

  localparam int TIMER_DIV_DEF = 4096;
  localparam int PI_SYNC_DEF   = 2;
  localparam int CNT_W         = 16;

  // Dispatch priority: NXM > PI > TIMER
  function automatic grant_e pick_grant(input logic nxm, input logic pi, input logic tim);
    if (nxm)      return GNT_NXM;
    else if (pi)  return GNT_PI;
    else if (tim) return GNT_TIM;
    else          return GNT_NONE;
  endfunction

  // Offer vector ordered {nxm, pi, tim}
  function automatic logic [2:0] grant_onehot(input grant_e g);
    case (g)
      GNT_NXM: return 3'b100;
      GNT_PI:  return 3'b010;
      GNT_TIM: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/intr_sync.sv
// STAGES-deep level synchronizer with asynchronous active-low reset.
// Runs on every clock edge, independent of any clock enable.
module intr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/intr_sched.sv
// Interrupt request scheduler: pending latches, interval-timer prescaler and
// one-at-a-time offer FSM. Define INTR_SCHED_STATS_EN for grant counters.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter int TIMER_DIV = TIMER_DIV_DEF,
  parameter int PI_SYNC   = PI_SYNC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        piREQ,
  input  logic        nxmREQ,
  input  logic        timerEN,
  input  logic        intrACK,
  input  logic        timerCLR,
  output logic        nxmINTR,
  output logic        piINTR,
  output logic        timerINTR,
`ifdef INTR_SCHED_STATS_EN
  output logic [0:47] statsCNT,
`endif
  output logic        timerOVR
);

  localparam logic [15:0] DIV_LAST = 16'(TIMER_DIV - 1);

  logic        w_pi_sync;
  logic        w_tick;
  logic        w_ack;
  grant_e      w_pick;
  logic [15:0] r_pre;
  logic        r_nxm_pend;
  logic        r_tim_pend;
  logic        r_tim_ovr;
  state_e      r_state;
  grant_e      r_grant;
  logic [2:0]  r_offer;

  intr_sync #(.STAGES(PI_SYNC)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (piREQ),
    .o_q (w_pi_sync)
  );

  assign w_tick = timerEN && (r_pre == DIV_LAST);
  assign w_ack  = (r_state == ST_OFFER) && intrACK;
  assign w_pick = pick_grant(r_nxm_pend, w_pi_sync, r_tim_pend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_pre <= '0;
    else if (clken) begin
      if (!timerEN || w_tick)  r_pre <= '0;
      else                     r_pre <= r_pre + 16'd1;
    end
  end

  // A tick coinciding with timerCLR wins the pending bit but still clears overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tim_pend <= 1'b0;
      r_tim_ovr  <= 1'b0;
    end else if (clken) begin
      if (w_tick) begin
        r_tim_pend <= 1'b1;
        r_tim_ovr  <= !timerCLR && (r_tim_ovr || r_tim_pend);
      end else if (timerCLR) begin
        r_tim_pend <= 1'b0;
        r_tim_ovr  <= 1'b0;
      end else if (w_ack && r_grant == GNT_TIM) begin
        r_tim_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_nxm_pend <= 1'b0;
    else if (clken) begin
      if (nxmREQ)                              r_nxm_pend <= 1'b1;
      else if (w_ack && r_grant == GNT_NXM)    r_nxm_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_grant <= GNT_NONE;
      r_offer <= 3'b000;
    end else if (clken) begin
      case (r_state)
        ST_IDLE: if (w_pick != GNT_NONE) begin
          r_grant <= w_pick;
          r_offer <= grant_onehot(w_pick);
          r_state <= ST_OFFER;
        end
        ST_OFFER: if (intrACK) begin
          r_offer <= 3'b000;
          r_state <= ST_HOLD;
        end else if ((r_grant == GNT_PI && !w_pi_sync) ||
                     (r_grant == GNT_TIM && timerCLR)) begin
          r_offer <= 3'b000;
          r_grant <= GNT_NONE;
          r_state <= ST_IDLE;
        end
        ST_HOLD: begin
          r_grant <= GNT_NONE;
          r_state <= ST_IDLE;
        end
        default: begin
          r_offer <= 3'b000;
          r_grant <= GNT_NONE;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign {nxmINTR, piINTR, timerINTR} = r_offer;
  assign timerOVR = r_tim_ovr;

`ifdef INTR_SCHED_STATS_EN
  logic [CNT_W-1:0] r_nxm_cnt, r_pi_cnt, r_tim_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nxm_cnt <= '0;
      r_pi_cnt  <= '0;
      r_tim_cnt <= '0;
    end else if (clken && w_ack) begin
      case (r_grant)
        GNT_NXM: if (r_nxm_cnt != '1) r_nxm_cnt <= r_nxm_cnt + 1'b1;
        GNT_PI:  if (r_pi_cnt  != '1) r_pi_cnt  <= r_pi_cnt  + 1'b1;
        GNT_TIM: if (r_tim_cnt != '1) r_tim_cnt <= r_tim_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign statsCNT = {r_nxm_cnt, r_pi_cnt, r_tim_cnt};
`endif

endmodule
